xadc_drp_responder: RTL and testbench

Synthesizable responder for the XADC start-of-conversion / end-of-conversion handshake and the DRP register port. It emulates the on-die temperature channel, so the temperature readout path can be run in simulation and hardware bring-up without the XADC hard macro. It sits where the XADC IP normally sits, facing the DRP initiator. The conversion result comes from an external 12-bit code input and is served through a small DRP register map.

---
 rtl/xadc_drp_responder.sv | 195 +++++++++++++++++++
 tb/tb_xadc_drp_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_responder.sv
// Stand-in for the XADC temperature channel: SOC/EOC conversion handshake plus a
// small DRP register map (status, max, min, scratch) served from SensorCode.
//
// conversion FSM
//   state  | meaning
//   C_IDLE | waiting for AdcSoc
//   C_CONV | counting down to end of conversion, AdcBusy high
// DRP engine
//   state  | meaning
//   D_IDLE | waiting for DrpEn
//   D_WAIT | latency countdown, then DrpRdy + commit
module xadc_drp_responder #(
  parameter int CONV_CYCLES = 104,
  parameter int DRP_LAT     = 2
) (
  input  logic        AdcClk,
  input  logic        AdcRstN,
  input  logic        AdcSoc,
  input  logic [11:0] SensorCode,
  input  logic [6:0]  DrpAddr,
  input  logic        DrpEn,
  input  logic        DrpWe,
  input  logic [15:0] DrpDi,
  output logic [15:0] DrpDo,
  output logic        DrpRdy,
  output logic        AdcBusy,
  output logic        AdcEoc,
  output logic [4:0]  ChannelOut
);

  localparam logic [9:0] CONV_LOAD = 10'(CONV_CYCLES - 1);
  localparam logic [2:0] LAT_LOAD  = 3'(DRP_LAT - 1);

  typedef enum logic {C_IDLE, C_CONV} conv_state_e;
  typedef enum logic {D_IDLE, D_WAIT} drp_state_e;

  conv_state_e conv_state_q, conv_state_d;
  drp_state_e  drp_state_q, drp_state_d;
  logic [9:0]  conv_cnt_q, conv_cnt_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [11:0] code_q, code_d;
  logic [11:0] status_q, status_d;
  logic [11:0] max_q, max_d;
  logic [11:0] min_q, min_d;
  logic        busy_q, busy_d;
  logic        eoc_q, eoc_d;
  logic [6:0]  addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] di_q, di_d;
  logic [15:0] do_q, do_d;
  logic        rdy_q, rdy_d;
  logic [15:0] cfg0_q, cfg0_d;
  logic [15:0] cfg1_q, cfg1_d;
  logic [15:0] cfg2_q, cfg2_d;
  logic [15:0] rd_data;

  always_comb begin
    rd_data = 16'h0000;
    case (addr_q)
      7'h00:   rd_data = {status_q, 4'b0000};
      7'h20:   rd_data = {max_q, 4'b0000};
      7'h24:   rd_data = {min_q, 4'b0000};
      7'h40:   rd_data = cfg0_q;
      7'h41:   rd_data = cfg1_q;
      7'h42:   rd_data = cfg2_q;
      default: rd_data = 16'h0000;
    endcase
  end

  always_comb begin
    conv_state_d = conv_state_q;
    conv_cnt_d   = conv_cnt_q;
    code_d       = code_q;
    status_d     = status_q;
    max_d        = max_q;
    min_d        = min_q;
    busy_d       = busy_q;
    eoc_d        = 1'b0;
    case (conv_state_q)
      C_IDLE: begin
        if (AdcSoc) begin
          conv_state_d = C_CONV;
          code_d       = SensorCode;
          busy_d       = 1'b1;
          conv_cnt_d   = CONV_LOAD;
        end
      end
      C_CONV: begin
        if (conv_cnt_q == 10'd0) begin
          conv_state_d = C_IDLE;
          eoc_d        = 1'b1;
          busy_d       = 1'b0;
          status_d     = code_q;
          if (code_q > max_q) max_d = code_q;
          if (code_q < min_q) min_d = code_q;
        end else begin
          conv_cnt_d = conv_cnt_q - 10'd1;
        end
      end
      default: conv_state_d = C_IDLE;
    endcase
  end

  always_comb begin
    drp_state_d = drp_state_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    di_d        = di_q;
    do_d        = do_q;
    rdy_d       = 1'b0;
    cfg0_d      = cfg0_q;
    cfg1_d      = cfg1_q;
    cfg2_d      = cfg2_q;
    case (drp_state_q)
      D_IDLE: begin
        if (DrpEn) begin
          drp_state_d = D_WAIT;
          addr_d      = DrpAddr;
          we_d        = DrpWe;
          di_d        = DrpDi;
          lat_cnt_d   = LAT_LOAD;
        end
      end
      D_WAIT: begin
        if (lat_cnt_q == 3'd0) begin
          drp_state_d = D_IDLE;
          rdy_d       = 1'b1;
          do_d        = rd_data;
          // only the scratch registers accept writes; everything else drops them
          if (we_q) begin
            case (addr_q)
              7'h40:   cfg0_d = di_q;
              7'h41:   cfg1_d = di_q;
              7'h42:   cfg2_d = di_q;
              default: ;
            endcase
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      default: drp_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge AdcClk or negedge AdcRstN) begin
    if (!AdcRstN) begin
      conv_state_q <= C_IDLE;
      conv_cnt_q   <= 10'd0;
      code_q       <= 12'h000;
      status_q     <= 12'h000;
      max_q        <= 12'h000;
      min_q        <= 12'hFFF;
      busy_q       <= 1'b0;
      eoc_q        <= 1'b0;
      drp_state_q  <= D_IDLE;
      lat_cnt_q    <= 3'd0;
      addr_q       <= 7'h00;
      we_q         <= 1'b0;
      di_q         <= 16'h0000;
      do_q         <= 16'h0000;
      rdy_q        <= 1'b0;
      cfg0_q       <= 16'h0000;
      cfg1_q       <= 16'h0000;
      cfg2_q       <= 16'h0000;
    end else begin
      conv_state_q <= conv_state_d;
      conv_cnt_q   <= conv_cnt_d;
      code_q       <= code_d;
      status_q     <= status_d;
      max_q        <= max_d;
      min_q        <= min_d;
      busy_q       <= busy_d;
      eoc_q        <= eoc_d;
      drp_state_q  <= drp_state_d;
      lat_cnt_q    <= lat_cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      di_q         <= di_d;
      do_q         <= do_d;
      rdy_q        <= rdy_d;
      cfg0_q       <= cfg0_d;
      cfg1_q       <= cfg1_d;
      cfg2_q       <= cfg2_d;
    end
  end

  assign DrpDo      = do_q;
  assign DrpRdy     = rdy_q;
  assign AdcBusy    = busy_q;
  assign AdcEoc     = eoc_q;
  assign ChannelOut = 5'h00;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Bench for xadc_drp_responder: expected DRP read data is queued when a read is
// issued and popped when DrpRdy arrives; conversion timing is counted in cycles.
module tb_xadc_drp_responder;

  localparam int CONV_CYCLES = 104;
  localparam int DRP_LAT     = 2;

  logic        AdcClk;
  logic        AdcRstN;
  logic        AdcSoc;
  logic [11:0] SensorCode;
  logic [6:0]  DrpAddr;
  logic        DrpEn;
  logic        DrpWe;
  logic [15:0] DrpDi;
  logic [15:0] DrpDo;
  logic        DrpRdy;
  logic        AdcBusy;
  logic        AdcEoc;
  logic [4:0]  ChannelOut;

  int n_vec  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  xadc_drp_responder #(.CONV_CYCLES(CONV_CYCLES), .DRP_LAT(DRP_LAT)) dut (
    .AdcClk(AdcClk), .AdcRstN(AdcRstN), .AdcSoc(AdcSoc), .SensorCode(SensorCode),
    .DrpAddr(DrpAddr), .DrpEn(DrpEn), .DrpWe(DrpWe), .DrpDi(DrpDi),
    .DrpDo(DrpDo), .DrpRdy(DrpRdy), .AdcBusy(AdcBusy), .AdcEoc(AdcEoc),
    .ChannelOut(ChannelOut)
  );

  initial AdcClk = 1'b0;
  always #5 AdcClk = ~AdcClk;

  task automatic tick();
    @(posedge AdcClk);
    #1;
  endtask

  // Issues one DRP transaction starting in the current cycle and waits for DrpRdy.
  task automatic drp_txn(input logic [6:0] a, input logic we, input logic [15:0] di,
                         input logic [15:0] exp, input string name);
    int k;
    logic [15:0] e;
    if (!we) exp_q.push_back(exp);
    DrpAddr = a; DrpWe = we; DrpDi = di; DrpEn = 1'b1;
    tick();
    DrpEn = 1'b0; DrpWe = 1'b0;
    k = 0;
    while (!DrpRdy && k < 20) begin
      tick();
      k++;
    end
    n_vec++;
    if (k !== DRP_LAT) begin
      n_fail++;
      $display("FAIL %s rdy_latency got %0d want %0d", name, k, DRP_LAT);
    end
    if (!we && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (DrpDo !== e) begin
        n_fail++;
        $display("FAIL %s drpdo got %h want %h", name, DrpDo, e);
      end
    end
  endtask

  task automatic wait_eoc(output int k, input int limit);
    k = 0;
    while (!AdcEoc && k < limit) begin
      tick();
      k++;
    end
  endtask

  task automatic check_int(input int got, input int want, input string name);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    AdcRstN = 1'b0; AdcSoc = 1'b0; SensorCode = 12'h000;
    DrpAddr = 7'h00; DrpEn = 1'b0; DrpWe = 1'b0; DrpDi = 16'h0000;
    repeat (3) tick();
    AdcRstN = 1'b1;
    tick();
    n_vec++;
    if ({DrpDo, DrpRdy, AdcBusy, AdcEoc, ChannelOut} !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_outputs got do=%h rdy=%b busy=%b eoc=%b ch=%h want all zero",
               DrpDo, DrpRdy, AdcBusy, AdcEoc, ChannelOut);
    end
    drp_txn(7'h24, 1'b0, 16'h0, 16'hFFF0, "reset_min");
    drp_txn(7'h20, 1'b0, 16'h0, 16'h0000, "reset_max");
    drp_txn(7'h00, 1'b0, 16'h0, 16'h0000, "reset_status");
  endtask

  task automatic test_conversion();
    int k;
    SensorCode = 12'hA5C; AdcSoc = 1'b1;
    tick();
    AdcSoc = 1'b0; SensorCode = 12'h000;
    check_int(int'(AdcBusy), 1, "conv_busy_rise");
    wait_eoc(k, 300);
    check_int(k, CONV_CYCLES, "conv_eoc_latency");
    check_int(int'(AdcBusy), 0, "conv_busy_fall");
    drp_txn(7'h00, 1'b0, 16'h0, 16'hA5C0, "conv_status_on_eoc");
  endtask

  task automatic test_extremes();
    int k;
    SensorCode = 12'h800; AdcSoc = 1'b1;
    tick();
    AdcSoc = 1'b0;
    repeat (30) tick();
    SensorCode = 12'h123; AdcSoc = 1'b1;
    tick();
    AdcSoc = 1'b0;
    wait_eoc(k, 300);
    check_int(k, CONV_CYCLES - 31, "ext_soc_ignored_latency");
    drp_txn(7'h42, 1'b1, 16'hBEEF, 16'h0, "ext_write_on_eoc");
    drp_txn(7'h00, 1'b0, 16'h0, 16'h8000, "ext_status_800");
    drp_txn(7'h42, 1'b0, 16'h0, 16'hBEEF, "ext_scratch_readback");
    wait_eoc(k, 150);
    check_int(k, 150, "ext_no_extra_eoc");

    SensorCode = 12'hFFF; AdcSoc = 1'b1;
    tick();
    AdcSoc = 1'b0;
    wait_eoc(k, 300);
    check_int(k, CONV_CYCLES, "ext_fff_latency");
    SensorCode = 12'h001; AdcSoc = 1'b1;
    tick();
    AdcSoc = 1'b0;
    check_int(int'(AdcBusy), 1, "ext_back_to_back_busy");
    wait_eoc(k, 300);
    check_int(k, CONV_CYCLES, "ext_001_latency");
    drp_txn(7'h20, 1'b0, 16'h0, 16'hFFF0, "ext_max");
    drp_txn(7'h24, 1'b0, 16'h0, 16'h0010, "ext_min");
    drp_txn(7'h00, 1'b0, 16'h0, 16'h0010, "ext_status_001");
  endtask

  task automatic test_drp_writes();
    int pulses;
    logic [15:0] e;
    drp_txn(7'h41, 1'b1, 16'h1234, 16'h0, "wr_scratch");
    drp_txn(7'h41, 1'b0, 16'h0, 16'h1234, "rd_scratch");
    drp_txn(7'h00, 1'b1, 16'hFFFF, 16'h0, "wr_ro_status");
    drp_txn(7'h00, 1'b0, 16'h0, 16'h0010, "rd_status_unchanged");
    drp_txn(7'h7F, 1'b0, 16'h0, 16'h0000, "rd_unmapped");
    drp_txn(7'h40, 1'b0, 16'h0, 16'h0000, "rd_cfg0");

    exp_q.push_back(16'h1234);
    DrpAddr = 7'h41; DrpWe = 1'b0; DrpEn = 1'b1;
    tick();
    DrpAddr = 7'h00;
    tick();
    DrpEn = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (DrpRdy) begin
        pulses++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_vec++;
          if (DrpDo !== e) begin
            n_fail++;
            $display("FAIL wait_en_data got %h want %h", DrpDo, e);
          end
        end
      end
      tick();
    end
    check_int(pulses, 1, "wait_en_single_rdy");
  endtask

  task automatic test_reset_mid();
    int k;
    SensorCode = 12'h777; AdcSoc = 1'b1;
    tick();
    AdcSoc = 1'b0;
    repeat (49) tick();
    AdcRstN = 1'b0;
    #1;
    n_vec++;
    if ({AdcBusy, AdcEoc, DrpRdy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got busy=%b eoc=%b rdy=%b want 000", AdcBusy, AdcEoc, DrpRdy);
    end
    repeat (3) tick();
    AdcRstN = 1'b1;
    wait_eoc(k, 200);
    check_int(k, 200, "rst_mid_no_eoc");
    drp_txn(7'h00, 1'b0, 16'h0, 16'h0000, "rst_mid_status");
    drp_txn(7'h20, 1'b0, 16'h0, 16'h0000, "rst_mid_max");
    drp_txn(7'h24, 1'b0, 16'h0, 16'hFFF0, "rst_mid_min");
    drp_txn(7'h41, 1'b0, 16'h0, 16'h0000, "rst_mid_cfg1");
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_extremes();
    test_drp_writes();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
